// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared arbiter FSM encodings, bus signal levels and PCI command codes
package pci_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_TURN  = 2'd3
    } arb_state_t;

    // PCI control lines are active-low
    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    localparam logic [3:0] CMD_READ  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0011;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select
// Ports:
//   req_vec  in   N   active-high request per agent
//   ptr      in   3   index of last served agent; search starts at ptr+1
//   winner   out  3   index of the chosen agent (0 when nothing requests)
//   any_req  out  1   at least one request present
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_vec,
    input  logic [2:0]   ptr,
    output logic [2:0]   winner,
    output logic         any_req
);

    // Requests duplicated side by side so a plain low-to-high priority scan
    // over the window (ptr, ptr+N] covers the wrap-around in one pass.
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] mask;
    logic           found;

    assign dbl     = {req_vec, req_vec};
    assign any_req = |req_vec;

    always_comb begin
        for (int j = 0; j < 2*N; j++) begin
            mask[j] = (j > int'(ptr)) && (j <= int'(ptr) + N);
        end
    end

    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int j = 0; j < 2*N; j++) begin
            if (!found && dbl[j] && mask[j]) begin
                found  = 1'b1;
                winner = (j >= N) ? 3'(j - N) : 3'(j);
            end
        end
    end

endmodule

// File: rtl/pci_arbiter.sv
// rtl/pci_arbiter.sv - round-robin PCI bus arbiter with unused-grant revocation
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   request      active-low per-agent request
//   grand        active-low per-agent grant, registered, at most one low
//   frame, irdy  active-low bus lines observed to track ownership
//   owner        index of the last granted agent
//   owner_vld    an agent holds a grant or runs a transaction
//   gnt_timeout  one-cycle pulse when an unused grant is revoked
module pci_arbiter
    import pci_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int GNT_TIMEOUT = 16,
    parameter int TMR_W       = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] request,
    output logic [N_MASTERS-1:0] grand,
    input  logic                 frame,
    input  logic                 irdy,
    output logic [2:0]           owner,
    output logic                 owner_vld,
    output logic                 gnt_timeout
);

    arb_state_t           state, state_n;
    logic [N_MASTERS-1:0] grand_n;
    logic [2:0]           owner_n, rr_ptr, rr_ptr_n;
    logic                 owner_vld_n, gnt_timeout_n;
    logic [TMR_W-1:0]     timer, timer_n;

    logic [N_MASTERS-1:0] req_vec;
    logic [2:0]           winner;
    logic                 any_req, frame_act, irdy_act, bus_idle, owner_req;

    // A released bus floats; only a definite low counts as asserted.
    assign frame_act = (frame === ASSERTED);
    assign irdy_act  = (irdy === ASSERTED);
    assign bus_idle  = !frame_act && !irdy_act;

    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            req_vec[i] = (request[i] === ASSERTED);
            if (owner == 3'(i)) begin
                owner_req = req_vec[i];
            end
        end
    end

    rr_picker #(.N(N_MASTERS)) u_picker (
        .req_vec (req_vec),
        .ptr     (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_n       = state;
        grand_n       = grand;
        owner_n       = owner;
        owner_vld_n   = owner_vld;
        rr_ptr_n      = rr_ptr;
        timer_n       = timer;
        gnt_timeout_n = 1'b0;
        case (state)
            ST_IDLE: begin
                grand_n = '1;
                if (any_req && bus_idle) begin
                    for (int i = 0; i < N_MASTERS; i++) begin
                        grand_n[i] = (winner != 3'(i));
                    end
                    owner_n     = winner;
                    rr_ptr_n    = winner;
                    owner_vld_n = 1'b1;
                    timer_n     = '0;
                    state_n     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Priority: bus started > request withdrawn > timer expiry
                if (frame_act) begin
                    grand_n = '1;
                    state_n = ST_BUSY;
                end else if (!owner_req) begin
                    grand_n     = '1;
                    owner_vld_n = 1'b0;
                    state_n     = ST_TURN;
                end else if (timer == TMR_W'(GNT_TIMEOUT - 1)) begin
                    grand_n       = '1;
                    gnt_timeout_n = 1'b1;
                    owner_vld_n   = 1'b0;
                    state_n       = ST_TURN;
                end else if (timer != '1) begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_BUSY: begin
                grand_n = '1;
                if (bus_idle) begin
                    owner_vld_n = 1'b0;
                    state_n     = ST_TURN;
                end
            end
            ST_TURN: begin
                grand_n = '1;
                state_n = ST_IDLE;
            end
            default: begin
                grand_n = '1;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            grand       <= '1;
            owner       <= '0;
            owner_vld   <= 1'b0;
            gnt_timeout <= 1'b0;
            timer       <= '0;
            rr_ptr      <= 3'(N_MASTERS - 1);
        end else begin
            state       <= state_n;
            grand       <= grand_n;
            owner       <= owner_n;
            owner_vld   <= owner_vld_n;
            gnt_timeout <= gnt_timeout_n;
            timer       <= timer_n;
            rr_ptr      <= rr_ptr_n;
        end
    end

endmodule
